uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that lets NUM_REQ byte sources share a single `uart_send` transmitter. It accepts bytes over a per-requester valid/ready handshake and drives the transmitter's level-sensitive `uart_en`/`uart_din` inputs. It sequences each byte through launch and completion by watching `uart_tx_busy`. It sits between the protocol/command logic and `uart_send` in the slave-driver reporting path.

---
 rtl/uart_tx_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that lets NUM_REQ byte sources share
// one uart_send transmitter. Bytes are accepted over a valid/ready handshake,
// launched with a level on uart_en, and tracked through uart_tx_busy.
// Optional packet lock: define UART_TX_ARB_LOCK_EN to keep the grant on one
// requester until it presents a byte with req_last set.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int IDX_W      = 2,
  parameter int LAUNCH_TMO = 8
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 uart_en,
  output logic [7:0]           uart_din,
  input  logic                 uart_tx_busy,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 arb_busy,
  output logic                 tx_err
);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    DRAIN
  } state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   ptr, ptr_n;
  logic [7:0]         tmo_cnt, tmo_cnt_n;
  logic [NUM_REQ-1:0] req_ready_n;
  logic               uart_en_n;
  logic [7:0]         uart_din_n;
  logic [IDX_W-1:0]   grant_idx_n;
  logic               tx_err_n;

  logic [NUM_REQ-1:0] eligible;
  logic               win_vld;
  logic [IDX_W-1:0]   win_idx;
  logic [7:0]         win_data;

`ifdef UART_TX_ARB_LOCK_EN
  logic               lock_vld, lock_vld_n;
  logic [IDX_W-1:0]   lock_idx, lock_idx_n;
  logic               win_last;
`else
  logic               unused_last;
  assign unused_last = ^req_last;
`endif

  // Requesters allowed to compete this cycle (only the locked one while a packet is open).
  always_comb begin
    eligible = req_valid;
`ifdef UART_TX_ARB_LOCK_EN
    if (lock_vld) eligible = req_valid & (NUM_REQ'(1) << lock_idx);
`endif
  end

  // Round-robin pick: first eligible index searching upward from ptr+1.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    win_data = '0;
`ifdef UART_TX_ARB_LOCK_EN
    win_last = 1'b0;
`endif
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!win_vld && eligible[i] && ((int'(ptr) + k) % NUM_REQ) == i) begin
          win_vld  = 1'b1;
          win_idx  = IDX_W'(i);
          win_data = req_data[8*i +: 8];
`ifdef UART_TX_ARB_LOCK_EN
          win_last = req_last[i];
`endif
        end
      end
    end
  end

  // Next-state and next-output logic for the IDLE/LAUNCH/DRAIN sequencer.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_n     = state;
    ptr_n       = ptr;
    tmo_cnt_n   = tmo_cnt;
    req_ready_n = '0;
    uart_en_n   = uart_en;
    uart_din_n  = uart_din;
    grant_idx_n = grant_idx;
    tx_err_n    = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
    lock_vld_n  = lock_vld;
    lock_idx_n  = lock_idx;
`endif
    case (state)
      IDLE: begin
        uart_en_n = 1'b0;
        tmo_cnt_n = '0;
        // Waiting for busy=0 keeps a frame still running after reset from being overlapped.
        if (win_vld && !uart_tx_busy) begin
          uart_din_n           = win_data;
          uart_en_n            = 1'b1;
          grant_idx_n          = win_idx;
          ptr_n                = win_idx;
          req_ready_n[win_idx] = 1'b1;
          state_n              = LAUNCH;
`ifdef UART_TX_ARB_LOCK_EN
          lock_vld_n = !win_last;
          lock_idx_n = win_idx;
`endif
        end
      end
      LAUNCH: begin
        uart_en_n = 1'b1;
        if (uart_tx_busy) begin
          uart_en_n = 1'b0;
          state_n   = DRAIN;
        end else if (tmo_cnt == 8'(LAUNCH_TMO - 1)) begin
          // Transmitter never answered: drop the byte and release any packet lock.
          uart_en_n = 1'b0;
          tx_err_n  = 1'b1;
          state_n   = IDLE;
`ifdef UART_TX_ARB_LOCK_EN
          lock_vld_n = 1'b0;
`endif
        end else begin
          tmo_cnt_n = tmo_cnt + 8'd1;
        end
      end
      DRAIN: begin
        uart_en_n = 1'b0;
        if (!uart_tx_busy) state_n = IDLE;
      end
      default: begin
        uart_en_n = 1'b0;
        state_n   = IDLE;
      end
    endcase
  end

  // State and registered outputs; synchronous active-high reset.
  always_ff @(posedge sys_clk) begin
    // NOTE: non-blocking assignments so every register updates from the
    // values present before the edge, independent of statement order.
    if (sys_rst) begin
      state     <= IDLE;
      ptr       <= IDX_W'(NUM_REQ - 1);
      tmo_cnt   <= '0;
      req_ready <= '0;
      uart_en   <= 1'b0;
      uart_din  <= '0;
      grant_idx <= '0;
      arb_busy  <= 1'b0;
      tx_err    <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
      lock_vld  <= 1'b0;
      lock_idx  <= '0;
`endif
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      tmo_cnt   <= tmo_cnt_n;
      req_ready <= req_ready_n;
      uart_en   <= uart_en_n;
      uart_din  <= uart_din_n;
      grant_idx <= grant_idx_n;
      arb_busy  <= (state_n != IDLE);
      tx_err    <= tx_err_n;
`ifdef UART_TX_ARB_LOCK_EN
      lock_vld  <= lock_vld_n;
      lock_idx  <= lock_idx_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: queue-fed requesters, a stub transmitter
// that raises busy two cycles after each uart_en rise, and a scoreboard of
// expected (byte, grant) pairs compared when each frame starts.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int IDX_W      = 2;
  localparam int LAUNCH_TMO = 8;
  localparam int FRAME      = 10;

  typedef struct packed {
    logic [7:0]       data;
    logic [IDX_W-1:0] idx;
  } exp_t;

  logic                 sys_clk = 1'b0;
  logic                 sys_rst;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [8*NUM_REQ-1:0] req_data  = '0;
  logic [NUM_REQ-1:0]   req_last  = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 uart_en;
  logic [7:0]           uart_din;
  logic                 uart_tx_busy = 1'b0;
  logic [IDX_W-1:0]     grant_idx;
  logic                 arb_busy;
  logic                 tx_err;

  uart_tx_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .IDX_W     (IDX_W),
    .LAUNCH_TMO(LAUNCH_TMO)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .uart_en     (uart_en),
    .uart_din    (uart_din),
    .uart_tx_busy(uart_tx_busy),
    .grant_idx   (grant_idx),
    .arb_busy    (arb_busy),
    .tx_err      (tx_err)
  );

  always #5 sys_clk = ~sys_clk;

  exp_t       sb[$];
  logic [8:0] rq[NUM_REQ][$];
  int         checks = 0;
  int         errors = 0;

  // Stub transmitter / monitor state.
  logic en_prev = 1'b0;
  int   cyc = 0, en_run = 0, last_run = 0, dly = 0, frame_cnt = 0;
  int   fall_cyc = 0, err_cnt = 0, err_run = 0, drops_done = 0;
  int   drop_req = 0;
  bit   fall_valid = 1'b0;
  bit   gap_chk = 1'b0;
  logic err_arb = 1'b0, err_en = 1'b0;
  exp_t got_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic expect_byte(input logic [7:0] data, input logic [IDX_W-1:0] idx);
    exp_t e;
    e.data = data;
    e.idx  = idx;
    sb.push_back(e);
  endtask

  function automatic bit rq_empty();
    for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      tick();
      done = (sb.size() == 0) && rq_empty() && !arb_busy && !uart_tx_busy;
    end
    check(tag, done, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"},    uart_en,   0);
    check({tag, "_din"},   uart_din,  0);
    check({tag, "_ready"}, req_ready, 0);
    check({tag, "_grant"}, grant_idx, 0);
    check({tag, "_busy"},  arb_busy,  0);
    check({tag, "_err"},   tx_err,    0);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    tick();
    tick();
    sys_rst = 1'b0;
    tick();
  endtask

  // Requester model: retire the head byte on ready, present the next one.
  always begin
    @(posedge sys_clk);
    #1;
    if (req_ready != '0) check("ready_onehot", $countones(req_ready), 1);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i] && rq[i].size() != 0) void'(rq[i].pop_front());
      if (rq[i].size() != 0) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = rq[i][0][7:0];
        req_last[i]        = rq[i][0][8];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
  end

  // Stub transmitter: busy rises two cycles after an uart_en rise, lasts FRAME cycles.
  always @(negedge sys_clk) begin
    cyc++;
    if (sys_rst) fall_valid = 1'b0;
    if (uart_en) en_run++;
    else if (en_prev) begin
      last_run = en_run;
      en_run   = 0;
    end
    if (tx_err) begin
      err_cnt++;
      err_run = last_run;
      err_arb = arb_busy;
      err_en  = uart_en;
    end
    if (uart_tx_busy) begin
      frame_cnt--;
      if (frame_cnt == 0) begin
        uart_tx_busy = 1'b0;
        fall_cyc     = cyc;
        fall_valid   = 1'b1;
      end
    end else if (dly > 0) begin
      dly--;
      if (dly == 0) begin
        uart_tx_busy = 1'b1;
        frame_cnt    = FRAME;
        if (sb.size() == 0) begin
          check("frame_unexpected", sb.size(), 1);
        end else begin
          got_exp = sb.pop_front();
          check("frame_data",  uart_din,  got_exp.data);
          check("frame_grant", grant_idx, got_exp.idx);
        end
      end
    end
    if (uart_en && !en_prev) begin
      if (gap_chk && fall_valid) check("frame_gap", cyc - fall_cyc, 2);
      fall_valid = 1'b0;
      if (drops_done < drop_req) drops_done++;
      else dly = 2;
    end
    en_prev = uart_en;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    sys_rst = 1'b1;
    repeat (3) tick();
    sys_rst = 1'b0;
    tick();
    check_reset_outputs("rst");

    // Single byte from requester 0.
    rq[0].push_back({1'b1, 8'h55});
    expect_byte(8'h55, 2'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = (req_ready != '0);
    end
    check("t1_ready",     req_ready, 4'b0001);
    check("t1_en",        uart_en,   1);
    check("t1_din",       uart_din,  8'h55);
    check("t1_grant",     grant_idx, 0);
    check("t1_arb_busy",  arb_busy,  1);
    tick();
    check("t1_ready_one", req_ready, 0);
    check("t1_en_hold",   uart_en,   1);
    wait_idle("t1_idle");
    check("t1_en_width",  last_run,  3);
    check("t1_din_held",  uart_din,  8'h55);

    // All four valid: strict rotation with a 2-cycle inter-frame gap.
    do_reset();
    gap_chk = 1'b1;
    rq[0].push_back({1'b1, 8'h10});
    rq[0].push_back({1'b1, 8'h10});
    rq[1].push_back({1'b1, 8'h11});
    rq[2].push_back({1'b1, 8'h12});
    rq[3].push_back({1'b1, 8'h13});
    expect_byte(8'h10, 2'd0);
    expect_byte(8'h11, 2'd1);
    expect_byte(8'h12, 2'd2);
    expect_byte(8'h13, 2'd3);
    expect_byte(8'h10, 2'd0);
    wait_idle("t2_idle");
    gap_chk = 1'b0;

    // Transmitter ignores the first launch: timeout, error pulse, next requester.
    do_reset();
    drop_req = 1;
    rq[0].push_back({1'b1, 8'h33});
    rq[1].push_back({1'b1, 8'h44});
    expect_byte(8'h44, 2'd1);
    wait_idle("t3_idle");
    check("t3_err_count", err_cnt, 1);
    check("t3_en_width",  err_run, LAUNCH_TMO);
    check("t3_err_arb",   err_arb, 0);
    check("t3_err_en",    err_en,  0);

    // Reset while draining: no acceptance until the running frame ends.
    do_reset();
    rq[0].push_back({1'b1, 8'h77});
    expect_byte(8'h77, 2'd0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      found = arb_busy && !uart_en && uart_tx_busy;
    end
    check("t4_drain", found, 1);
    rq[1].push_back({1'b1, 8'h88});
    expect_byte(8'h88, 2'd1);
    sys_rst = 1'b1;
    tick();
    tick();
    check_reset_outputs("t4_rst");
    sys_rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      found = (req_ready != '0);
    end
    check("t4_ready",       req_ready, 4'b0010);
    check("t4_busy_accept", uart_tx_busy, 0);
    check("t4_accept_lat",  cyc - fall_cyc, 1);
    check("t4_en",          uart_en,   1);
    check("t4_din",         uart_din,  8'h88);
    wait_idle("t4_idle");

    // Packet lock: requester 1 sends a two-byte packet while requester 0 waits.
    do_reset();
    rq[0].push_back({1'b1, 8'h01});
    expect_byte(8'h01, 2'd0);
    wait_idle("t5_prep");
    rq[1].push_back({1'b0, 8'hA0});
    rq[1].push_back({1'b1, 8'hA1});
    rq[0].push_back({1'b1, 8'h0B});
`ifdef UART_TX_ARB_LOCK_EN
    expect_byte(8'hA0, 2'd1);
    expect_byte(8'hA1, 2'd1);
    expect_byte(8'h0B, 2'd0);
`else
    expect_byte(8'hA0, 2'd1);
    expect_byte(8'h0B, 2'd0);
    expect_byte(8'hA1, 2'd1);
`endif
    wait_idle("t5_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
